// File: rtl/inverse_symbol_generator.sv
// Single-rail 16-QAM amplitude slicer: maps each signed lane sample to a level code 1..4.
// It registers the packed codes plus a flag that is set when the lanes disagree.
module inverse_symbol_generator #(
  parameter int LANE_W = 16,
  parameter int LANES  = 4,
  parameter int TH1    = 15,
  parameter int TH2    = 25,
  parameter int TH3    = 35
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [LANE_W*LANES-1:0]   in_data,
  output logic                      out_valid,
  output logic [4*LANES-1:0]        out_data,
  output logic                      out_mismatch
);

  localparam logic signed [LANE_W-1:0] TH1_L = TH1[LANE_W-1:0];
  localparam logic signed [LANE_W-1:0] TH2_L = TH2[LANE_W-1:0];
  localparam logic signed [LANE_W-1:0] TH3_L = TH3[LANE_W-1:0];

  logic [4*LANES-1:0] code_w;
  logic [LANES-1:0]   lane_diff_w;

  logic               valid_q, valid_d;
  logic [4*LANES-1:0] data_q, data_d;
  logic               mismatch_q, mismatch_d;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [LANE_W-1:0] sample_w;
      logic [3:0]               code_lane_w;

      assign sample_w = in_data[gi*LANE_W +: LANE_W];

      // A sample sitting exactly on a threshold takes the higher code.
      always_comb begin
        code_lane_w = 4'h1;
        if (sample_w >= TH3_L)      code_lane_w = 4'h4;
        else if (sample_w >= TH2_L) code_lane_w = 4'h3;
        else if (sample_w >= TH1_L) code_lane_w = 4'h2;
      end

      assign code_w[gi*4 +: 4] = code_lane_w;
      assign lane_diff_w[gi]   = (code_lane_w != code_w[3:0]);
    end
  endgenerate

  always_comb begin
    valid_d    = in_valid;
    data_d     = data_q;
    mismatch_d = mismatch_q;
    if (in_valid) begin
      data_d     = code_w;
      mismatch_d = |lane_diff_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      mismatch_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_mismatch = mismatch_q;

endmodule

// File: tb/tb_inverse_symbol_generator.sv
// Directed bench: two slicer instances (in-phase and quadrature rails), checks on the falling edge.
module tb_inverse_symbol_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_a, in_b;
  logic        ov_a, ov_b, mm_a, mm_b;
  logic [15:0] od_a, od_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inverse_symbol_generator u_i (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_a),
    .out_valid(ov_a), .out_data(od_a), .out_mismatch(mm_a)
  );

  inverse_symbol_generator u_q (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_b),
    .out_valid(ov_b), .out_data(od_b), .out_mismatch(mm_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs right after a falling edge and advance to the next falling edge.
  task automatic cyc(input logic v, input logic [63:0] a, input logic [63:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [15:0] d, input logic m);
    chk({tag, "_valid"}, {15'd0, ov_a}, {15'd0, v});
    chk({tag, "_data"},  od_a, d);
    chk({tag, "_mm"},    {15'd0, mm_a}, {15'd0, m});
    $display("step %-10s valid=%0b data=%h mm=%0b", tag, ov_a, od_a, mm_a);
  endtask

  logic [15:0] i_val [16];
  logic [15:0] q_val [16];
  logic [15:0] i_exp [16];
  logic [15:0] q_exp [16];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    i_val = '{16'd20, 16'd10, 16'd40, 16'd30, 16'd20, 16'd10, 16'd40, 16'd30,
              16'd20, 16'd10, 16'd40, 16'd30, 16'd20, 16'd10, 16'd40, 16'd30};
    i_exp = '{16'h2222, 16'h1111, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h4444, 16'h3333,
              16'h2222, 16'h1111, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h4444, 16'h3333};
    q_val = '{16'd40, 16'd40, 16'd40, 16'd40, 16'd30, 16'd30, 16'd30, 16'd30,
              16'd20, 16'd20, 16'd20, 16'd20, 16'd10, 16'd10, 16'd10, 16'd10};
    q_exp = '{16'h4444, 16'h4444, 16'h4444, 16'h4444, 16'h3333, 16'h3333, 16'h3333, 16'h3333,
              16'h2222, 16'h2222, 16'h2222, 16'h2222, 16'h1111, 16'h1111, 16'h1111, 16'h1111};

    // Reset state, with valid data presented while reset is held.
    @(negedge clk);
    cyc(1'b1, 64'h0028002800280028, 64'h0028002800280028);
    chk_a("reset", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;

    // Nominal levels, back-to-back.
    cyc(1'b1, 64'h0014001400140014, '0); chk_a("nom20", 1'b1, 16'h2222, 1'b0);
    cyc(1'b1, 64'h000a000a000a000a, '0); chk_a("nom10", 1'b1, 16'h1111, 1'b0);
    cyc(1'b1, 64'h0028002800280028, '0); chk_a("nom40", 1'b1, 16'h4444, 1'b0);
    cyc(1'b1, 64'h001e001e001e001e, '0); chk_a("nom30", 1'b1, 16'h3333, 1'b0);

    // 16-QAM sweep on both rails, one result per cycle.
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, {4{i_val[k]}}, {4{q_val[k]}});
      chk($sformatf("sweep_i%0d", k), od_a, i_exp[k]);
      chk($sformatf("sweep_q%0d", k), od_b, q_exp[k]);
      chk($sformatf("sweep_v%0d", k), {14'd0, ov_a, ov_b}, 16'h0003);
      $display("sweep %0d i=%h q=%h", k, od_a, od_b);
    end

    // Threshold boundaries.
    cyc(1'b1, 64'h00190018000f000e, '0); chk_a("thr_lo", 1'b1, 16'h3221, 1'b1);
    cyc(1'b1, 64'h7fffffff00230022, '0); chk_a("thr_hi", 1'b1, 16'h4143, 1'b1);
    cyc(1'b1, 64'h8000800080008000, '0); chk_a("thr_min", 1'b1, 16'h1111, 1'b0);
    cyc(1'b1, 64'h0023002300230023, '0); chk_a("thr_35", 1'b1, 16'h4444, 1'b0);

    // Mixed word, then a gap that must hold the result.
    cyc(1'b1, 64'h0014000a00280014, '0); chk_a("mixed", 1'b1, 16'h2142, 1'b1);
    cyc(1'b0, 64'h0028002800280028, '0); chk_a("hold", 1'b0, 16'h2142, 1'b1);
    cyc(1'b1, 64'h000a000a000a000a, '0); chk_a("resume", 1'b1, 16'h1111, 1'b0);

    // Asynchronous reset mid-cycle while a result is being shown.
    in_valid = 1'b1; in_a = 64'h0028002800280028;
    @(posedge clk); #2;
    chk("pre_rst_data", od_a, 16'h4444);
    rst = 1'b1; #1;
    chk_a("async_rst", 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    chk_a("rst_held", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 64'h001e001e001e001e, '0); chk_a("post_rst", 1'b1, 16'h3333, 1'b0);
    cyc(1'b0, '0, '0);                   chk_a("post_idle", 1'b0, 16'h3333, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
